// File: rtl/fpu_issue.sv
// fpu_issue: core-side issue port to the FPU coprocessor register port.
// Latches one op, holds cs until ready or timeout, then returns a one-cycle writeback.
module fpu_issue #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned LATW    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic [2:0]      req_func,
  input  logic [31:0]     req_rs1,
  input  logic [31:0]     req_rs2,
  input  logic [31:0]     req_rdr,
  output logic            stall,
  output logic            wb_en,
  output logic [31:0]     wb_data,
  output logic            err,
  output logic [LATW-1:0] lat_cycles,
  output logic            cp_cs,
  output logic [2:0]      cp_func,
  input  logic            cp_ready,
  output logic [31:0]     CPR_RS1,
  output logic [31:0]     CPR_RS2,
  output logic [31:0]     CPR_RDR,
  input  logic [31:0]     CPR_RDW
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [LATW-1:0] TO_LAST = LATW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [LATW-1:0] cnt_q, cnt_d;
  logic [LATW-1:0] cnt_inc_s;
  logic            cs_q, cs_d;
  logic            stall_q, stall_d;
  logic            wb_en_q, wb_en_d;
  logic            err_q, err_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [LATW-1:0] lat_q, lat_d;
  logic [2:0]      func_q, func_d;
  logic [31:0]     rs1_q, rs1_d;
  logic [31:0]     rs2_q, rs2_d;
  logic [31:0]     rdr_q, rdr_d;

  // Latency count sticks at all-ones instead of wrapping.
  assign cnt_inc_s = (cnt_q == {LATW{1'b1}}) ? cnt_q : cnt_q + LATW'(1);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ready has priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cp_ready) begin
          state_d = ST_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    cs_d      = 1'b0;
    stall_d   = 1'b0;
    wb_en_d   = 1'b0;
    err_d     = 1'b0;
    wb_data_d = wb_data_q;
    lat_d     = lat_q;
    cnt_d     = cnt_q;
    func_d    = func_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rdr_d     = rdr_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          func_d  = req_func;
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          rdr_d   = req_rdr;
          cnt_d   = {LATW{1'b0}};
          cs_d    = 1'b1;
          stall_d = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_WAIT: begin
        stall_d = 1'b1;
        cnt_d   = cnt_inc_s;
        if (cp_ready) begin
          wb_data_d = CPR_RDW;
          lat_d     = cnt_inc_s;
          wb_en_d   = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          err_d = 1'b1;
        end else begin
          cs_d = 1'b1;
        end
      end
      // DONE forces a cs-low cycle so the coprocessor can return to idle.
      ST_DONE: stall_d = 1'b0;
      default: stall_d = 1'b0;
    endcase
  end

  // Output and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q      <= 1'b0;
      stall_q   <= 1'b0;
      wb_en_q   <= 1'b0;
      err_q     <= 1'b0;
      wb_data_q <= 32'h0000_0000;
      lat_q     <= {LATW{1'b0}};
      cnt_q     <= {LATW{1'b0}};
      func_q    <= 3'd0;
      rs1_q     <= 32'h0000_0000;
      rs2_q     <= 32'h0000_0000;
      rdr_q     <= 32'h0000_0000;
    end else begin
      cs_q      <= cs_d;
      stall_q   <= stall_d;
      wb_en_q   <= wb_en_d;
      err_q     <= err_d;
      wb_data_q <= wb_data_d;
      lat_q     <= lat_d;
      cnt_q     <= cnt_d;
      func_q    <= func_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rdr_q     <= rdr_d;
    end
  end

  assign cp_cs      = cs_q;
  assign stall      = stall_q;
  assign wb_en      = wb_en_q;
  assign err        = err_q;
  assign wb_data    = wb_data_q;
  assign lat_cycles = lat_q;
  assign cp_func    = func_q;
  assign CPR_RS1    = rs1_q;
  assign CPR_RS2    = rs2_q;
  assign CPR_RDR    = rdr_q;

endmodule

// File: tb/tb_fpu_issue.sv
// tb_fpu_issue: randomized bench for fpu_issue with a transaction-level timing model.
// Each accepted op is described by its accept edge and responder delay; outputs follow arithmetically.
module tb_fpu_issue;

  localparam int T    = 8;
  localparam int LATW = 9;
  localparam int NCYC = 900;

  logic            clk;
  logic            rst;
  logic            req;
  logic [2:0]      req_func;
  logic [31:0]     req_rs1, req_rs2, req_rdr;
  logic            stall, wb_en, err, cp_cs, cp_ready;
  logic [31:0]     wb_data;
  logic [LATW-1:0] lat_cycles;
  logic [2:0]      cp_func;
  logic [31:0]     CPR_RS1, CPR_RS2, CPR_RDR, CPR_RDW;

  fpu_issue #(.TIMEOUT(T), .LATW(LATW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_func(req_func),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rdr(req_rdr),
    .stall(stall), .wb_en(wb_en), .wb_data(wb_data), .err(err),
    .lat_cycles(lat_cycles), .cp_cs(cp_cs), .cp_func(cp_func),
    .cp_ready(cp_ready), .CPR_RS1(CPR_RS1), .CPR_RS2(CPR_RS2),
    .CPR_RDR(CPR_RDR), .CPR_RDW(CPR_RDW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  logic chk_en = 1'b0;

  // Model of the current/last op: accepted at edge a, responder answers in cs cycle d.
  int   p = 0, a = 0, k = 0, d = 0, n_ops = 0;
  logic act = 1'b0, ok = 1'b0;
  logic [31:0] pend_rdw = 32'h0;
  logic        exp_cs = 1'b0, exp_stall = 1'b0, exp_wben = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_wb = 32'h0, exp_rs1 = 32'h0, exp_rs2 = 32'h0, exp_rdr = 32'h0;
  logic [LATW-1:0] exp_lat = '0;
  logic [2:0]  exp_func = 3'd0;

  // Observations used by the literal pins.
  int   runs[$];
  int   evs[$];
  int   run = 0;
  logic got_first = 1'b0, rst_done = 1'b0;
  logic [31:0] first_wb = 32'h0;
  logic [LATW-1:0] first_lat = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %h want %h at cycle %0d", name, got, want, p);
    end
  endtask

  task automatic drive();
    int j;
    logic in_cs_now;
    in_cs_now = act && (p >= a) && (p <= a + k - 1);
    req      = (n_ops < 4) ? 1'b1 : ($urandom_range(0, 3) != 0);
    req_func = 3'($urandom);
    req_rs1  = $urandom;
    req_rs2  = $urandom;
    req_rdr  = $urandom;
    if (n_ops == 0) begin
      req_func = 3'd1;
      req_rs1  = 32'h4040_0000;
      req_rs2  = 32'h3F80_0000;
    end
    CPR_RDW = $urandom;
    if (in_cs_now) begin
      j = p - a + 1;
      cp_ready = (j == d);
      if (cp_ready) begin
        if (n_ops == 1) CPR_RDW = 32'h4080_0000;
        pend_rdw = CPR_RDW;
      end
    end else begin
      cp_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic model_step();
    if (act && p == a + k && ok) begin
      exp_wb  = pend_rdw;
      exp_lat = LATW'(k);
    end
    if (req && (!act || p >= a + k + 2)) begin
      case (n_ops)
        0:       d = 3;
        1:       d = T + 5;
        2:       d = T;
        3:       d = 1;
        default: d = $urandom_range(1, T + 2);
      endcase
      act      = 1'b1;
      a        = p;
      ok       = (d <= T);
      k        = ok ? d : T;
      exp_func = req_func;
      exp_rs1  = req_rs1;
      exp_rs2  = req_rs2;
      exp_rdr  = req_rdr;
      n_ops++;
    end
    exp_cs    = act && (p >= a) && (p <= a + k - 1);
    exp_stall = act && (p >= a) && (p <= a + k);
    exp_wben  = act && (p == a + k) && ok;
    exp_err   = act && (p == a + k) && !ok;
  endtask

  task automatic observe();
    if (cp_cs) begin
      run++;
    end else if (run != 0) begin
      runs.push_back(run);
      run = 0;
    end
    if (wb_en) evs.push_back(1);
    if (err) evs.push_back(2);
    if (wb_en && !got_first) begin
      got_first = 1'b1;
      first_wb  = wb_data;
      first_lat = lat_cycles;
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    chk("rst_cs", 32'(cp_cs), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_rs1", CPR_RS1, 32'd0);
    act = 1'b0; exp_cs = 1'b0; exp_stall = 1'b0; exp_wben = 1'b0; exp_err = 1'b0;
    exp_wb = 32'h0; exp_lat = '0; exp_func = 3'd0;
    exp_rs1 = 32'h0; exp_rs2 = 32'h0; exp_rdr = 32'h0;
    rst_done = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cp_cs", 32'(cp_cs), 32'(exp_cs));
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("wb_en", 32'(wb_en), 32'(exp_wben));
      chk("err", 32'(err), 32'(exp_err));
      chk("wb_data", wb_data, exp_wb);
      chk("lat_cycles", 32'(lat_cycles), 32'(exp_lat));
      chk("cp_func", 32'(cp_func), 32'(exp_func));
      chk("CPR_RS1", CPR_RS1, exp_rs1);
      chk("CPR_RS2", CPR_RS2, exp_rs2);
      chk("CPR_RDR", CPR_RDR, exp_rdr);
    end
  end

  initial begin
    rst = 1'b1; req = 1'b0; req_func = 3'd0;
    req_rs1 = 32'h0; req_rs2 = 32'h0; req_rdr = 32'h0;
    cp_ready = 1'b0; CPR_RDW = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    for (int it = 0; it < NCYC; it++) begin
      drive();
      @(posedge clk);
      #1;
      p++;
      observe();
      model_step();
      if (!rst_done && n_ops == 7 && exp_cs) do_reset();
    end
    @(negedge clk);
    #1;
    chk("first_wb_data", first_wb, 32'h4080_0000);
    chk("first_lat", 32'(first_lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("cs_run%0d", i), (i < runs.size()) ? runs[i] : 0,
          (i == 0) ? 3 : (i == 3) ? 1 : T);
      chk($sformatf("event%0d", i), (i < evs.size()) ? evs[i] : 0, (i == 1) ? 2 : 1);
    end
    chk("reset_seen", 32'(rst_done), 32'd1);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
